// File: rtl/instr_encoder.sv
// MIPS field-to-word encoder feeding a small output FIFO, with a word-address
// counter that tracks the FIFO head for instruction-memory writes.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [15:0]   imm16,
  input  logic [25:0]   addr26,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [AW-1:0] out_addr,
  input  logic          addr_load,
  input  logic [AW-1:0] addr_value,
  output logic          err,
  output logic [4:0]    err_op
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  // Returns {supported, word}; fields not used by a format are never placed.
  function automatic logic [32:0] encode(
    input logic [4:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_sh,
    input logic [15:0] f_imm,
    input logic [25:0] f_addr
  );
    logic [32:0] r;
    r = 33'd0;
    case (op)
      5'd0:  r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20};
      5'd1:  r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h22};
      5'd2:  r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h24};
      5'd3:  r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h25};
      5'd4:  r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h27};
      5'd5:  r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h2A};
      5'd6:  r = {1'b1, 6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h00};
      5'd7:  r = {1'b1, 6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h02};
      5'd8:  r = {1'b1, 6'h00, f_rs, 15'd0, 6'h08};
      5'd9:  r = {1'b1, 6'h08, f_rs, f_rt, f_imm};
      5'd10: r = {1'b1, 6'h0C, f_rs, f_rt, f_imm};
      5'd11: r = {1'b1, 6'h0D, f_rs, f_rt, f_imm};
      5'd12: r = {1'b1, 6'h04, f_rs, f_rt, f_imm};
      5'd13: r = {1'b1, 6'h05, f_rs, f_rt, f_imm};
      5'd14: r = {1'b1, 6'h23, f_rs, f_rt, f_imm};
      5'd15: r = {1'b1, 6'h2B, f_rs, f_rt, f_imm};
      5'd16: r = {1'b1, 6'h02, f_addr};
      5'd17: r = {1'b1, 6'h03, f_addr};
      default: r = 33'd0;
    endcase
    return r;
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [32:0]   enc_p0;
  logic          accept, push, pop;
  logic [AW-1:0] addr_cnt;

  assign count     = wr_ptr - rd_ptr;
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign enc_p0    = encode(op_sel, rs, rt, rd, shamt, imm16, addr26);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_p0[32];
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr[IW-1:0]] : 32'd0;
  assign out_addr  = addr_cnt;

  // Stage p0 -> FIFO storage: data path carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= enc_p0[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_cnt <= '0;
      err      <= 1'b0;
      err_op   <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (addr_load)
        addr_cnt <= addr_value;
      else if (pop)
        addr_cnt <= addr_cnt + AW'(1);
      // Only the first unsupported code is kept for diagnosis.
      if (accept && !enc_p0[32]) begin
        err <= 1'b1;
        if (!err) err_op <= op_sel;
      end
    end
  end

endmodule
